// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory controller and mem_responder.
//   req   : request valid, held by the requester until ack
//   we    : 1 = write, 0 = read
//   addr  : byte address (ADDR_W bits)
//   wdata : write data
//   rdata : registered read data, valid with ack when !err and the request was a read
//   ack   : one-cycle completion pulse
//   err   : rejected request, only ever high together with ack
//   busy  : responder is not idle
// master = requester side, slave = responder side.
interface mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;
    logic              err;
    logic              busy;

    modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU memory port.
// Captures one single-word read/write request in IDLE, waits WAIT_STATES
// cycles, performs the access, then pulses ack (with err on rejection).
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : mem_responder_if slave modport (req/we/addr/wdata in,
//         rdata/ack/err/busy out)
// The storage array is not cleared by reset.
module mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_responder_if.slave    bus
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("mem_responder: WAIT_STATES must be in 0..15");
    end
    if (DEPTH_LOG2 + 2 > ADDR_W) begin : g_bad_depth
        $error("mem_responder: DEPTH_LOG2+2 exceeds ADDR_W");
    end

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH];

    logic                  capture;
    logic                  access;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] index;

    assign capture = (state == S_IDLE) && bus.req;
    assign access  = (state == S_WAIT) && (cnt == '0);
    assign index   = addr_q[DEPTH_LOG2+1:2];
    // Out of range = any address bit above the word index is set.
    assign acc_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.req) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (capture) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                cnt     <= 4'(WAIT_STATES);
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                err_q <= acc_err;
                if (!acc_err && !we_q) begin
                    rdata_q <= mem[index];
                end
            end
        end
    end

    // Array kept out of the reset domain; the write is gated by the
    // registered state, so reset asserted during WAIT drops it.
    always_ff @(posedge clk) begin
        if (access && we_q && !acc_err) begin
            mem[index] <= wdata_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = (state == S_RESP);
    assign bus.err   = (state == S_RESP) && err_q;
    assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(32)) m2 ();
    mem_responder_if #(.ADDR_W(32)) m0 ();

    mem_responder #(.ADDR_W(32), .DEPTH_LOG2(8), .WAIT_STATES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (m2.slave)
    );

    mem_responder #(.ADDR_W(32), .DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (m0.slave)
    );

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    exp_t e2;
    exp_t e0;
    logic [31:0] last_rd2 = '0;
    logic [31:0] last_rd0 = '0;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitors: pop one expectation per ack.
    always @(negedge clk) begin
        if (rst) begin
            if (m2.ack) begin
                if (q2.size() == 0) begin
                    checks++;
                    $display("FAIL ack2_unexpected: got ack=1 expected no ack");
                end else begin
                    e2 = q2.pop_front();
                    chk("ack2_err", {31'b0, m2.err}, {31'b0, e2.err});
                    chk("ack2_rdata", m2.rdata, e2.rd);
                end
            end else if (m2.err) begin
                chk("err2_without_ack", {31'b0, m2.err}, 32'd0);
            end
            if (m0.ack) begin
                if (q0.size() == 0) begin
                    checks++;
                    $display("FAIL ack0_unexpected: got ack=1 expected no ack");
                end else begin
                    e0 = q0.pop_front();
                    chk("ack0_err", {31'b0, m0.err}, {31'b0, e0.err});
                    chk("ack0_rdata", m0.rdata, e0.rd);
                end
            end else if (m0.err) begin
                chk("err0_without_ack", {31'b0, m0.err}, 32'd0);
            end
        end
    end

    task automatic push_exp(input bit sel0, input logic we, input logic exp_err,
                            input logic [31:0] rd);
        exp_t e;
        e.we  = we;
        e.err = exp_err;
        if (sel0) begin
            if (!we && !exp_err) last_rd0 = rd;
            e.rd = last_rd0;
            q0.push_back(e);
        end else begin
            if (!we && !exp_err) last_rd2 = rd;
            e.rd = last_rd2;
            q2.push_back(e);
        end
    endtask

    // One transaction; lat = negedges from capture edge until ack seen.
    task automatic xfer(input bit sel0, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] rd, output int lat);
        bit got = 0;
        lat = -1;
        push_exp(sel0, we, exp_err, rd);
        @(negedge clk);
        if (sel0) begin m0.req = 1; m0.we = we; m0.addr = addr; m0.wdata = wdata; end
        else      begin m2.req = 1; m2.we = we; m2.addr = addr; m2.wdata = wdata; end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((sel0 ? m0.ack : m2.ack) && !got) begin
                got = 1;
                lat = i;
                break;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL xfer_timeout: got no ack expected ack within 20 cycles");
        end
        if (sel0) m0.req = 0; else m2.req = 0;
    endtask

    int lat;
    int ack_cyc[3];
    int nack;

    initial begin
        m2.req = 0; m2.we = 0; m2.addr = '0; m2.wdata = '0;
        m0.req = 0; m0.we = 0; m0.addr = '0; m0.wdata = '0;

        // 1: reset then idle
        repeat (2) @(negedge clk);
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_rdata", m2.rdata, 32'd0);
            chk("idle_flags", {29'b0, m2.ack, m2.err, m2.busy}, 32'd0);
            chk("idle0_flags", {29'b0, m0.ack, m0.err, m0.busy}, 32'd0);
        end

        // 2: write/read with WAIT_STATES=2
        xfer(0, 1, 32'h10, 32'hDEADBEEF, 0, '0, lat);
        chk("lat_ws2", lat, 32'd4);
        xfer(0, 0, 32'h10, '0, 0, 32'hDEADBEEF, lat);
        xfer(0, 1, 32'h0, 32'h11111111, 0, '0, lat);
        xfer(0, 1, 32'h4, 32'h22222222, 0, '0, lat);
        xfer(0, 1, 32'h8, 32'h33333333, 0, '0, lat);

        // 3: latency with WAIT_STATES=0
        xfer(1, 1, 32'h0, 32'hCAFEF00D, 0, '0, lat);
        chk("lat_ws0", lat, 32'd2);
        push_exp(1, 0, 0, 32'hCAFEF00D);
        @(negedge clk);
        m0.req = 1; m0.we = 0; m0.addr = 32'h0;
        @(negedge clk);
        chk("ws0_after_t", {30'b0, m0.busy, m0.ack}, 32'b10);
        @(negedge clk);
        chk("ws0_after_t1", {30'b0, m0.busy, m0.ack}, 32'b11);
        m0.req = 0;
        @(negedge clk);
        chk("ws0_after_t2", {30'b0, m0.busy, m0.ack}, 32'b00);

        // 4: rejected requests leave storage and rdata alone
        xfer(0, 1, 32'h13, 32'hBAD0BAD0, 1, '0, lat);
        xfer(0, 1, 32'h400, 32'hBAD1BAD1, 1, '0, lat);
        xfer(0, 0, 32'h10, '0, 0, 32'hDEADBEEF, lat);
        xfer(0, 0, 32'h0, '0, 0, 32'h11111111, lat);

        // 5: req held high across three reads
        push_exp(0, 0, 0, 32'h11111111);
        push_exp(0, 0, 0, 32'h22222222);
        push_exp(0, 0, 0, 32'h33333333);
        @(negedge clk);
        m2.req = 1; m2.we = 0; m2.addr = 32'h0;
        nack = 0;
        for (int c = 0; c < 40 && nack < 3; c++) begin
            @(negedge clk);
            if (m2.ack) begin
                ack_cyc[nack] = c;
                nack++;
                m2.addr = 32'(nack * 4);
                if (nack == 3) m2.req = 0;
            end
        end
        m2.req = 0;
        chk("held_ack_count", nack, 32'd3);
        if (nack == 3) begin
            chk("held_gap1", ack_cyc[1] - ack_cyc[0], 32'd5);
            chk("held_gap2", ack_cyc[2] - ack_cyc[1], 32'd5);
        end
        repeat (8) @(negedge clk);

        // 6: reset during WAIT discards the write
        xfer(0, 1, 32'h20, 32'hA5A5A5A5, 0, '0, lat);
        @(negedge clk);
        m2.req = 1; m2.we = 1; m2.addr = 32'h20; m2.wdata = 32'h12345678;
        @(negedge clk);
        chk("abort_busy_wait", {31'b0, m2.busy}, 32'd1);
        rst = 0;
        #1;
        chk("abort_busy_rst", {31'b0, m2.busy}, 32'd0);
        last_rd2 = '0;
        last_rd0 = '0;
        @(negedge clk);
        m2.req = 0;
        @(negedge clk);
        rst = 1;
        repeat (4) @(negedge clk);
        chk("abort_rdata_reset", m2.rdata, 32'd0);
        xfer(0, 0, 32'h20, '0, 0, 32'hA5A5A5A5, lat);

        repeat (5) @(negedge clk);
        chk("sb2_drained", q2.size(), 32'd0);
        chk("sb0_drained", q0.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
